// File: rtl/text_buffer.sv
// Character-cell text buffer: host-side write stream with a hardware cursor,
// pixel-side lookup returning the character code under each screen coordinate.
module text_buffer #(
  parameter int unsigned COLS = 80,
  parameter int unsigned ROWS = 60
) (
  input  logic       px_clk,
  input  logic       reset,
  input  logic [9:0] pos_x,
  input  logic [9:0] pos_y,
  input  logic       active,
  input  logic       wr_valid,
  input  logic [7:0] wr_char,
  output logic       wr_ready,
  input  logic       clear,
  output logic       busy,
  output logic [7:0] character,
  output logic [9:0] out_x,
  output logic [9:0] out_y,
  output logic       char_valid,
  output logic [6:0] cursor_col,
  output logic [5:0] cursor_row
);

  localparam int unsigned CELLS = COLS * ROWS;
  localparam int unsigned AW    = $clog2(CELLS);

  localparam logic [7:0]    SPACE     = 8'h20;
  localparam logic [7:0]    CODE_LF   = 8'h0A;
  localparam logic [7:0]    CODE_CR   = 8'h0D;
  localparam logic [AW-1:0] LAST_ADDR = AW'(CELLS - 1);
  localparam logic [AW-1:0] COLS_A    = AW'(COLS);
  localparam logic [6:0]    LAST_COL  = 7'(COLS - 1);
  localparam logic [5:0]    LAST_ROW  = 6'(ROWS - 1);

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_IDLE  = 1'b1
  } state_t;

  state_t        state;
  state_t        state_next;
  logic [AW-1:0] clr_addr;
  logic          clr_last;
  logic          accept;
  logic          is_ctrl;
  logic [5:0]    row_inc;

  logic          mem_we;
  logic [AW-1:0] mem_waddr;
  logic [7:0]    mem_wdata;
  logic [AW-1:0] cur_addr;

  logic [6:0]    rd_col;
  logic [6:0]    rd_row;
  logic [AW-1:0] rd_addr;
  logic          rd_in_grid;

  logic [7:0]    mem [CELLS];

  assign clr_last = (clr_addr == LAST_ADDR);
  assign accept   = wr_valid & wr_ready;
  assign is_ctrl  = (wr_char == CODE_LF) || (wr_char == CODE_CR);
  assign row_inc  = (cursor_row == LAST_ROW) ? 6'd0 : cursor_row + 6'd1;
  assign cur_addr = AW'(cursor_row) * COLS_A + AW'(cursor_col);

  // State register
  always_ff @(posedge px_clk) begin
    if (reset) begin
      state <= ST_CLEAR;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic
  always_comb begin
    state_next = state;
    case (state)
      ST_CLEAR: if (clr_last) state_next = ST_IDLE;
      ST_IDLE:  if (clear)    state_next = ST_CLEAR;
      default:                state_next = ST_CLEAR;
    endcase
  end

  // Outputs and RAM write port control; a clear request drops a coincident write
  always_comb begin
    wr_ready  = 1'b0;
    busy      = 1'b0;
    mem_we    = 1'b0;
    mem_waddr = cur_addr;
    mem_wdata = wr_char;
    case (state)
      ST_CLEAR: begin
        busy      = 1'b1;
        mem_we    = !reset;
        mem_waddr = clr_addr;
        mem_wdata = SPACE;
      end
      ST_IDLE: begin
        wr_ready = !clear;
        mem_we   = !reset && wr_valid && !clear && !is_ctrl;
      end
      default: ;
    endcase
  end

  // Clear sweep address and write cursor
  always_ff @(posedge px_clk) begin
    if (reset) begin
      clr_addr   <= '0;
      cursor_col <= '0;
      cursor_row <= '0;
    end else if (state == ST_CLEAR) begin
      clr_addr <= clr_last ? '0 : clr_addr + AW'(1);
    end else if (clear) begin
      clr_addr   <= '0;
      cursor_col <= '0;
      cursor_row <= '0;
    end else if (accept) begin
      if (wr_char == CODE_LF) begin
        cursor_col <= '0;
        cursor_row <= row_inc;
      end else if (wr_char == CODE_CR) begin
        cursor_col <= '0;
      end else if (cursor_col == LAST_COL) begin
        cursor_col <= '0;
        cursor_row <= row_inc;
      end else begin
        cursor_col <= cursor_col + 7'd1;
      end
    end
  end

  assign rd_col     = pos_x[9:3];
  assign rd_row     = pos_y[9:3];
  assign rd_in_grid = active && (32'(rd_col) < COLS) && (32'(rd_row) < ROWS);
  assign rd_addr    = AW'(rd_row) * COLS_A + AW'(rd_col);

  // Write port
  always_ff @(posedge px_clk) begin
    if (mem_we) begin
      mem[mem_waddr] <= mem_wdata;
    end
  end

  // Registered read port; same-edge writes are seen on the following read
  always_ff @(posedge px_clk) begin
    if (reset) begin
      character  <= SPACE;
      out_x      <= '0;
      out_y      <= '0;
      char_valid <= 1'b0;
    end else begin
      character  <= rd_in_grid ? mem[rd_addr] : SPACE;
      out_x      <= pos_x;
      out_y      <= pos_y;
      char_valid <= rd_in_grid;
    end
  end

endmodule

// File: tb/tb_text_buffer.sv
// Scoreboard bench for text_buffer: probes push expected outputs, a monitor
// pops and compares one cycle later.
module tb_text_buffer;

  logic       px_clk;
  logic       reset;
  logic [9:0] pos_x;
  logic [9:0] pos_y;
  logic       active;
  logic       wr_valid;
  logic [7:0] wr_char;
  logic       wr_ready;
  logic       clear;
  logic       busy;
  logic [7:0] character;
  logic [9:0] out_x;
  logic [9:0] out_y;
  logic       char_valid;
  logic [6:0] cursor_col;
  logic [5:0] cursor_row;

  text_buffer dut (
    .px_clk     (px_clk),
    .reset      (reset),
    .pos_x      (pos_x),
    .pos_y      (pos_y),
    .active     (active),
    .wr_valid   (wr_valid),
    .wr_char    (wr_char),
    .wr_ready   (wr_ready),
    .clear      (clear),
    .busy       (busy),
    .character  (character),
    .out_x      (out_x),
    .out_y      (out_y),
    .char_valid (char_valid),
    .cursor_col (cursor_col),
    .cursor_row (cursor_row)
  );

  typedef struct packed {
    logic [9:0] x;
    logic [9:0] y;
    logic [7:0] ch;
    logic       cv;
    logic [6:0] col;
    logic [5:0] row;
    logic       busy;
    logic       rdy;
  } exp_t;

  exp_t exp_q [$];
  exp_t mon_e;
  int   mon_n;
  int   checks;
  int   errors;
  logic probe;
  logic probe_q;
  logic rdy_q;

  initial px_clk = 1'b0;
  always #5 px_clk = ~px_clk;

  // wr_ready is captured during the probe cycle, everything else after its edge
  always @(posedge px_clk) begin
    probe_q <= probe;
    rdy_q   <= wr_ready;
  end

  task automatic chk(input string nm, input int idx, input logic [31:0] act, input logic [31:0] exp_v);
    checks++;
    if (act !== exp_v) begin
      errors++;
      $display("FAIL probe %0d %s: got 0x%0h, expected 0x%0h", idx, nm, act, exp_v);
    end
  endtask

  always @(negedge px_clk) begin
    if (probe_q) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL scoreboard: output with no expectation queued, got 0, expected 1");
      end else begin
        mon_e = exp_q.pop_front();
        mon_n++;
        chk("out_x",      mon_n, 32'(out_x),      32'(mon_e.x));
        chk("out_y",      mon_n, 32'(out_y),      32'(mon_e.y));
        chk("character",  mon_n, 32'(character),  32'(mon_e.ch));
        chk("char_valid", mon_n, 32'(char_valid), 32'(mon_e.cv));
        chk("cursor_col", mon_n, 32'(cursor_col), 32'(mon_e.col));
        chk("cursor_row", mon_n, 32'(cursor_row), 32'(mon_e.row));
        chk("busy",       mon_n, 32'(busy),       32'(mon_e.busy));
        chk("wr_ready",   mon_n, 32'(rdy_q),      32'(mon_e.rdy));
      end
    end
  end

  task automatic cyc();
    @(posedge px_clk);
    #1;
  endtask

  task automatic wr(input logic [7:0] c);
    wr_valid = 1'b1;
    wr_char  = c;
    cyc();
    wr_valid = 1'b0;
  endtask

  task automatic probe_at(input logic [9:0] x, input logic [9:0] y, input logic a,
                          input logic [9:0] ex, input logic [9:0] ey, input logic [7:0] ech,
                          input logic ecv, input logic [6:0] ecol, input logic [5:0] erow,
                          input logic ebusy, input logic erdy);
    exp_t e;
    e.x = ex; e.y = ey; e.ch = ech; e.cv = ecv;
    e.col = ecol; e.row = erow; e.busy = ebusy; e.rdy = erdy;
    exp_q.push_back(e);
    pos_x  = x;
    pos_y  = y;
    active = a;
    probe  = 1'b1;
    cyc();
    probe  = 1'b0;
    active = 1'b0;
  endtask

  // In-grid read while idle
  task automatic rd(input logic [9:0] x, input logic [9:0] y, input logic [7:0] ech,
                    input logic [6:0] ecol, input logic [5:0] erow);
    probe_at(x, y, 1'b1, x, y, ech, 1'b1, ecol, erow, 1'b0, 1'b1);
  endtask

  // Called right after a reset edge: busy must hold for exactly 4800 cycles
  task automatic sweep_check();
    repeat (4798) cyc();
    probe_at(10'd0, 10'd0, 1'b1, 10'd0, 10'd0, 8'h20, 1'b1, 7'd0, 6'd0, 1'b1, 1'b0);
    probe_at(10'd0, 10'd0, 1'b1, 10'd0, 10'd0, 8'h20, 1'b1, 7'd0, 6'd0, 1'b0, 1'b0);
    probe_at(10'd639, 10'd479, 1'b1, 10'd639, 10'd479, 8'h20, 1'b1, 7'd0, 6'd0, 1'b0, 1'b1);
  endtask

  initial begin
    checks   = 0;
    errors   = 0;
    mon_n    = 0;
    probe    = 1'b0;
    reset    = 1'b1;
    pos_x    = '0;
    pos_y    = '0;
    active   = 1'b0;
    wr_valid = 1'b0;
    wr_char  = '0;
    clear    = 1'b0;

    // Reset values, then the power-up sweep
    cyc();
    probe_at(10'd3, 10'd5, 1'b1, 10'd0, 10'd0, 8'h20, 1'b0, 7'd0, 6'd0, 1'b1, 1'b0);
    reset = 1'b0;
    sweep_check();

    // Single write
    wr(8'h37);
    rd(10'd3, 10'd5, 8'h37, 7'd1, 6'd0);

    // Control codes
    wr(8'h41); wr(8'h42); wr(8'h0A); wr(8'h43);
    rd(10'd0, 10'd8, 8'h43, 7'd1, 6'd1);
    rd(10'd8, 10'd0, 8'h41, 7'd1, 6'd1);
    rd(10'd16, 10'd7, 8'h42, 7'd1, 6'd1);
    wr(8'h0D);
    rd(10'd2, 10'd9, 8'h43, 7'd0, 6'd1);

    // Read-before-write on the cell being written
    wr_valid = 1'b1;
    wr_char  = 8'h44;
    probe_at(10'd0, 10'd8, 1'b1, 10'd0, 10'd8, 8'h43, 1'b1, 7'd1, 6'd1, 1'b0, 1'b1);
    wr_valid = 1'b0;
    rd(10'd5, 10'd12, 8'h44, 7'd1, 6'd1);

    // Out of range and inactive
    probe_at(10'd640, 10'd10, 1'b1, 10'd640, 10'd10, 8'h20, 1'b0, 7'd1, 6'd1, 1'b0, 1'b1);
    probe_at(10'd8, 10'd480, 1'b1, 10'd8, 10'd480, 8'h20, 1'b0, 7'd1, 6'd1, 1'b0, 1'b1);
    probe_at(10'd8, 10'd0, 1'b0, 10'd8, 10'd0, 8'h20, 1'b0, 7'd1, 6'd1, 1'b0, 1'b1);
    rd(10'd632, 10'd472, 8'h20, 7'd1, 6'd1);

    // Row wrap by line feeds back to (0,0)
    wr(8'h0D);
    repeat (59) wr(8'h0A);
    rd(10'd0, 10'd0, 8'h37, 7'd0, 6'd0);

    // Full-screen fill wraps the cursor; next character overwrites (0,0)
    for (int i = 0; i < 4800; i++) begin
      wr(8'(33 + (i % 94)));
      if (i == 79) rd(10'd632, 10'd0, 8'h70, 7'd0, 6'd1);
    end
    rd(10'd0, 10'd0, 8'h21, 7'd0, 6'd0);
    rd(10'd639, 10'd479, 8'h26, 7'd0, 6'd0);
    rd(10'd8, 10'd8, 8'h72, 7'd0, 6'd0);
    wr(8'h7E);
    rd(10'd7, 10'd7, 8'h7E, 7'd1, 6'd0);

    // Clear beats a coincident write; sweep exposes old and cleared cells
    wr(8'h0D);
    for (int i = 0; i < 5; i++) wr(8'(8'h61 + i));
    clear    = 1'b1;
    wr_valid = 1'b1;
    wr_char  = 8'h5A;
    probe_at(10'd40, 10'd0, 1'b1, 10'd40, 10'd0, 8'h26, 1'b1, 7'd0, 6'd0, 1'b1, 1'b0);
    clear    = 1'b0;
    wr_valid = 1'b0;
    probe_at(10'd40, 10'd0, 1'b1, 10'd40, 10'd0, 8'h26, 1'b1, 7'd0, 6'd0, 1'b1, 1'b0);
    probe_at(10'd0, 10'd0, 1'b1, 10'd0, 10'd0, 8'h20, 1'b1, 7'd0, 6'd0, 1'b1, 1'b0);
    probe_at(10'd24, 10'd0, 1'b1, 10'd24, 10'd0, 8'h64, 1'b1, 7'd0, 6'd0, 1'b1, 1'b0);

    // Reset at sweep cycle 1000 restarts the full sweep
    repeat (996) cyc();
    reset = 1'b1;
    probe_at(10'd3, 10'd5, 1'b1, 10'd0, 10'd0, 8'h20, 1'b0, 7'd0, 6'd0, 1'b1, 1'b0);
    reset = 1'b0;
    sweep_check();

    repeat (2) cyc();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
